// File: rtl/elevator_pkg.sv
// Shared elevator definitions: dispatcher command encodings (also used by the
// dispatcher) and car FSM state encodings, plus a small elaboration helper.
package elevator_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_UP    = 2'b01,
    CMD_DOWN  = 2'b10,
    CMD_SERVE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    CAR_IDLE = 2'b00,
    CAR_MOVE = 2'b01,
    CAR_DOOR = 2'b10
  } car_state_e;

  // Larger of two values, for sizing the shared move/door timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/car_executor_if.sv
// Dispatcher <-> car command interface.
//   command          : dispatcher -> car, 2-bit cmd_e encoding
//   cur_floor        : car -> dispatcher, registered current floor
//   moving/dir_up    : car status (dir_up holds direction of current/last move)
//   door_open        : car status, door being serviced
//   serve_completing : last door cycle (Moore decode)
//   served_pulse     : one cycle pulse after the last door cycle
//   cmd_reject       : one cycle pulse on an out-of-range move request
interface car_executor_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned F_BITS = $clog2(N)
);
  logic [1:0]        command;
  logic [F_BITS-1:0] cur_floor;
  logic              moving;
  logic              dir_up;
  logic              door_open;
  logic              serve_completing;
  logic              served_pulse;
  logic              cmd_reject;

  modport master (
    output command,
    input  cur_floor, moving, dir_up, door_open, serve_completing, served_pulse, cmd_reject
  );

  modport slave (
    input  command,
    output cur_floor, moving, dir_up, door_open, serve_completing, served_pulse, cmd_reject
  );
endinterface

// File: rtl/car_timer.sv
// Loadable down-counter shared by the car's MOVE and DOOR phases.
//   clk, rst_n : clock, synchronous active-low reset (clears to 0)
//   load       : load load_val this cycle (wins over counting)
//   load_val   : reload value
//   value      : current count
//   zero       : count is 0; counting stops there
module car_timer #(
  parameter int unsigned T_BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [T_BITS-1:0] load_val,
  output logic [T_BITS-1:0] value,
  output logic              zero
);

  logic [T_BITS-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - T_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/car_executor.sv
// Car-side executor: accepts dispatcher commands in IDLE, runs timed
// floor-to-floor moves and door service, and reports status back.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : car_executor_if slave side (command in, status out)
module car_executor
  import elevator_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned F_BITS      = $clog2(N),
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 6,
  parameter int unsigned T_BITS      = $clog2(max_u(MOVE_CYCLES, DOOR_CYCLES) + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  car_executor_if.slave  bus
);

  localparam logic [F_BITS-1:0] TopFloor = F_BITS'(N - 1);
  localparam logic [T_BITS-1:0] MoveLoad = T_BITS'(MOVE_CYCLES - 1);
  localparam logic [T_BITS-1:0] DoorLoad = T_BITS'(DOOR_CYCLES - 1);

  car_state_e        state_q, state_d;
  logic [F_BITS-1:0] floor_q, floor_d;
  logic              dir_up_q, dir_up_d;
  logic              served_q, served_d;
  logic              reject_q, reject_d;

  logic              timer_load;
  logic [T_BITS-1:0] timer_load_val;
  logic [T_BITS-1:0] timer_value;
  logic              timer_zero;

  car_timer #(
    .T_BITS (T_BITS)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .value    (timer_value),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d        = state_q;
    floor_d        = floor_q;
    dir_up_d       = dir_up_q;
    served_d       = 1'b0;
    reject_d       = 1'b0;
    timer_load     = 1'b0;
    timer_load_val = '0;

    unique case (state_q)
      CAR_IDLE: begin
        case (bus.command)
          CMD_UP: begin
            if (floor_q != TopFloor) begin
              state_d        = CAR_MOVE;
              dir_up_d       = 1'b1;
              timer_load     = 1'b1;
              timer_load_val = MoveLoad;
            end else begin
              reject_d = 1'b1;
            end
          end
          CMD_DOWN: begin
            if (floor_q != '0) begin
              state_d        = CAR_MOVE;
              dir_up_d       = 1'b0;
              timer_load     = 1'b1;
              timer_load_val = MoveLoad;
            end else begin
              reject_d = 1'b1;
            end
          end
          CMD_SERVE: begin
            state_d        = CAR_DOOR;
            timer_load     = 1'b1;
            timer_load_val = DoorLoad;
          end
          default: ;  // CMD_IDLE: stay put
        endcase
      end
      CAR_MOVE: begin
        // Bounds were checked at acceptance, so the step cannot wrap.
        if (timer_zero) begin
          state_d = CAR_IDLE;
          floor_d = dir_up_q ? (floor_q + F_BITS'(1)) : (floor_q - F_BITS'(1));
        end
      end
      CAR_DOOR: begin
        if (timer_zero) begin
          state_d  = CAR_IDLE;
          served_d = 1'b1;
        end
      end
      default: state_d = CAR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CAR_IDLE;
      floor_q  <= '0;
      dir_up_q <= 1'b1;
      served_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_up_q <= dir_up_d;
      served_q <= served_d;
      reject_q <= reject_d;
    end
  end

  // Status outputs decode registered state only; no path from command.
  assign bus.cur_floor        = floor_q;
  assign bus.moving           = (state_q == CAR_MOVE);
  assign bus.dir_up           = dir_up_q;
  assign bus.door_open        = (state_q == CAR_DOOR);
  assign bus.serve_completing = (state_q == CAR_DOOR) && timer_zero;
  assign bus.served_pulse     = served_q;
  assign bus.cmd_reject       = reject_q;

endmodule

// File: tb/tb_car_executor.sv
// Scoreboard bench for car_executor: the driver keeps an operation-level model
// of the car and queues the expected completion events; the monitor turns the
// DUT's output waveforms into events and compares them against the queue.
module tb_car_executor;
  import elevator_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned MOVE = 8;
  localparam int unsigned DOOR = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  car_executor_if #(.N(N)) bus ();

  car_executor #(
    .N           (N),
    .MOVE_CYCLES (MOVE),
    .DOOR_CYCLES (DOOR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef enum int {EV_MOVE = 0, EV_DOOR = 1, EV_REJ = 2} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       floor;
    bit       dir_up;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Operation-level model: floor, direction, and how many clock edges the car
  // stays busy after accepting an operation.
  int m_floor = 0;
  int m_busy  = 0;
  bit m_dir   = 1'b1;

  task automatic model_step(input logic [1:0] c);
    ev_t e;
    if (m_busy > 0) begin
      m_busy--;
      return;
    end
    case (c)
      2'b01: begin
        if (m_floor < N - 1) begin
          m_floor++; m_dir = 1'b1; m_busy = MOVE;
          e = '{EV_MOVE, m_floor, 1'b1};
        end else e = '{EV_REJ, m_floor, m_dir};
        exp_q.push_back(e);
      end
      2'b10: begin
        if (m_floor > 0) begin
          m_floor--; m_dir = 1'b0; m_busy = MOVE;
          e = '{EV_MOVE, m_floor, 1'b0};
        end else e = '{EV_REJ, m_floor, m_dir};
        exp_q.push_back(e);
      end
      2'b11: begin
        m_busy = DOOR;
        e = '{EV_DOOR, m_floor, m_dir};
        exp_q.push_back(e);
      end
      default: ;
    endcase
  endtask

  // Inputs change 1 time unit after the falling edge; the monitor samples on it.
  task automatic drive(input logic [1:0] c);
    @(negedge clk);
    #1;
    bus.command = c;
    model_step(c);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.command = 2'b00;
    repeat (cycles - 1) @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    m_floor = 0; m_busy = 0; m_dir = 1'b1;
    exp_q.delete();
    model_step(2'b00);
  endtask

  // ---------------- monitor ----------------
  int mv_len = 0, dr_len = 0, sc_cnt = 0, sc_at = 0, prev_floor = 0;
  bit prev_mv = 1'b0;

  task automatic pop_check(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", k, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_floor", bus.cur_floor, e.floor);
      check("event_dir_up", bus.dir_up, e.dir_up);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_moving", bus.moving, 0);
      check("rst_door_open", bus.door_open, 0);
      check("rst_serve_completing", bus.serve_completing, 0);
      check("rst_served_pulse", bus.served_pulse, 0);
      check("rst_cmd_reject", bus.cmd_reject, 0);
      check("rst_cur_floor", bus.cur_floor, 0);
      check("rst_dir_up", bus.dir_up, 1);
      mv_len = 0; dr_len = 0; sc_cnt = 0; sc_at = 0;
      prev_mv = 1'b0; prev_floor = 0;
    end else begin
      if (bus.moving && bus.door_open) check("moving_and_door", 1, 0);
      if (bus.moving) mv_len++;
      if (bus.door_open) begin
        dr_len++;
        if (bus.serve_completing) begin
          sc_cnt++;
          sc_at = dr_len;
        end
      end else if (bus.serve_completing) begin
        check("completing_outside_door", 1, 0);
      end
      if (!bus.moving && prev_mv) begin
        check("move_len", mv_len, MOVE);
        pop_check(EV_MOVE);
        mv_len = 0;
      end else if (int'(bus.cur_floor) != prev_floor) begin
        check("floor_stable", bus.cur_floor, prev_floor);
      end
      if (bus.served_pulse) begin
        check("door_len", dr_len, DOOR);
        check("completing_count", sc_cnt, 1);
        check("completing_last", sc_at, DOOR);
        check("door_closed_at_pulse", bus.door_open, 0);
        pop_check(EV_DOOR);
        dr_len = 0; sc_cnt = 0; sc_at = 0;
      end
      if (bus.cmd_reject) pop_check(EV_REJ);
      prev_mv    = bus.moving;
      prev_floor = int'(bus.cur_floor);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    logic [1:0] c;
    int len;
    bus.command = 2'b00;
    do_reset(3);

    // Hold up: three moves to the top, then rejects at the top.
    repeat (32) drive(2'b01);
    // Hold down all the way to floor 0, then rejects at the bottom.
    repeat (32) drive(2'b10);
    // Up two floors and serve at floor 2.
    repeat (18) drive(2'b01);
    drive(2'b11);
    repeat (10) drive(2'b00);
    // Switch up->down in mid-move.
    repeat (3) drive(2'b01);
    repeat (12) drive(2'b10);
    repeat (3) drive(2'b00);

    // Random segments of held commands.
    for (int s = 0; s < 70; s++) begin
      c   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 14);
      repeat (len) drive(c);
    end

    // Reset during the third door cycle, away from floor 0.
    guard = 0;
    while (m_busy != 0 && guard < 50) begin drive(2'b00); guard++; end
    if (m_floor == 0) begin
      drive(2'b01);
      repeat (MOVE) drive(2'b00);
    end
    drive(2'b11);
    drive(2'b00);
    drive(2'b00);
    do_reset(1);
    repeat (20) drive(2'b00);

    // Short random tail after the abort, then drain.
    for (int s = 0; s < 10; s++) begin
      c   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 12);
      repeat (len) drive(c);
    end
    guard = 0;
    while ((exp_q.size() != 0 || m_busy != 0) && guard < 200) begin
      drive(2'b00);
      guard++;
    end
    repeat (3) drive(2'b00);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
